shared_mem_responder: RTL and testbench

Main-memory responder for the two-core snooping L1 system. It receives read/write-miss requests and write-backs from both direct-mapped L1 caches, holds off delivery for a fixed memory latency, cancels delivery when the peer cache announces it supplies the data, and returns the memory word on the requesting core's `mem_data_delivery`. It sits below both L1 caches, on the memory side of the snooping bus.

---
 rtl/snoop_bus_pkg.sv | 30 +++
 rtl/mem_miss_fsm.sv | 77 +++++++
 rtl/shared_mem_responder.sv | 135 +++++++++++++
 tb/tb_shared_mem_responder.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snoop_bus_pkg.sv
// Shared snooping-bus types: request encodings, miss FSM states and default widths
// used by both the L1 caches and the main-memory responder.
package snoop_bus_pkg;

  localparam int ADDR_W_DEF   = 9;
  localparam int DATA_W_DEF   = 32;
  localparam int NUM_CORES    = 2;
  localparam int NUM_WB_SLOTS = 4;

  typedef enum logic [1:0] {
    INVALIDATE = 2'b00,
    WRITE_MISS = 2'b01,
    READ_MISS  = 2'b10,
    NONE       = 2'b11
  } bus_req_t;

  typedef enum logic [1:0] {
    MISS_IDLE,
    MISS_WAIT,
    MISS_READ,
    MISS_DELIVER
  } miss_state_t;

  function automatic logic is_miss(input logic [1:0] req);
    bus_req_t r;
    r = bus_req_t'(req);
    return (r == WRITE_MISS) || (r == READ_MISS);
  endfunction

endpackage

// File: rtl/mem_miss_fsm.sv
// Per-core miss handler: latches the miss address, waits out the memory latency,
// honours peer aborts, stalls behind same-address write-backs, and registers the word.
module mem_miss_fsm
  import snoop_bus_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MISS_LATENCY = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [1:0]        bus_reply,
  input  logic [ADDR_W-1:0] ask_mem_address,
  input  logic              peer_abort,
  input  logic              wb_hazard,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] mem_data_delivery,
  output logic              mem_data_valid
);

  localparam int CNT_W = $clog2(MISS_LATENCY + 1);

  miss_state_t       state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] miss_addr_p0;

  assign rd_addr = miss_addr_p0;

  // Address latch is pure data; captured only when a miss is accepted.
  always_ff @(posedge clk) begin
    if (state == MISS_IDLE && is_miss(bus_reply)) begin
      miss_addr_p0 <= ask_mem_address;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state             <= MISS_IDLE;
      cnt               <= '0;
      mem_data_valid    <= 1'b0;
      mem_data_delivery <= '0;
    end else begin
      mem_data_valid <= 1'b0;
      case (state)
        MISS_IDLE: begin
          if (is_miss(bus_reply)) begin
            cnt   <= CNT_W'(MISS_LATENCY);
            state <= MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          if (peer_abort) begin
            state <= MISS_IDLE;
          end else if (cnt <= CNT_W'(1)) begin
            cnt   <= '0;
            state <= MISS_READ;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        MISS_READ: begin
          if (peer_abort) begin
            state <= MISS_IDLE;
          end else if (!wb_hazard) begin
            mem_data_delivery <= rd_data;
            mem_data_valid    <= 1'b1;
            state             <= MISS_DELIVER;
          end
        end
        MISS_DELIVER: state <= MISS_IDLE;
        default:      state <= MISS_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/shared_mem_responder.sv
// Main-memory responder below the two L1 caches: memory array, four write-back
// slots drained lowest-index first, sticky overflow flag, and one miss FSM per core.
module shared_mem_responder
  import snoop_bus_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MISS_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [1:0][1:0]        bus_reply,
  input  logic [1:0][ADDR_W-1:0] ask_mem_address,
  input  logic [1:0]             bus_reply_abort_mem_access,
  input  logic [1:0]             cpu_write_back,
  input  logic [1:0]             bus_write_back,
  input  logic [1:0][ADDR_W-1:0] address_out_mem_cpu,
  input  logic [1:0][ADDR_W-1:0] address_out_mem_bus,
  input  logic [1:0][DATA_W-1:0] data_out_mem_cpu,
  input  logic [1:0][DATA_W-1:0] data_out_mem_bus,
  output logic [1:0][DATA_W-1:0] mem_data_delivery,
  output logic [1:0]             mem_data_valid,
  output logic                   wb_overflow
);

  localparam int MEM_DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [0:MEM_DEPTH-1];

  logic [NUM_WB_SLOTS-1:0] wb_stb;
  logic [ADDR_W-1:0]       stb_addr  [NUM_WB_SLOTS];
  logic [DATA_W-1:0]       stb_data  [NUM_WB_SLOTS];
  logic [NUM_WB_SLOTS-1:0] slot_vld;
  logic [ADDR_W-1:0]       slot_addr [NUM_WB_SLOTS];
  logic [DATA_W-1:0]       slot_data [NUM_WB_SLOTS];
  logic [NUM_WB_SLOTS-1:0] drain_oh;
  logic [NUM_WB_SLOTS-1:0] slot_load;
  logic [ADDR_W-1:0]       drain_addr;
  logic [DATA_W-1:0]       drain_data;

  // Slot order: c0.cpu, c0.bus, c1.cpu, c1.bus.
  assign wb_stb = {bus_write_back[1], cpu_write_back[1], bus_write_back[0], cpu_write_back[0]};

  always_comb begin
    stb_addr[0] = address_out_mem_cpu[0];
    stb_addr[1] = address_out_mem_bus[0];
    stb_addr[2] = address_out_mem_cpu[1];
    stb_addr[3] = address_out_mem_bus[1];
    stb_data[0] = data_out_mem_cpu[0];
    stb_data[1] = data_out_mem_bus[0];
    stb_data[2] = data_out_mem_cpu[1];
    stb_data[3] = data_out_mem_bus[1];
  end

  // Lowest set bit of slot_vld wins the single memory write port.
  assign drain_oh  = slot_vld & (~slot_vld + NUM_WB_SLOTS'(1));
  assign slot_load = wb_stb & (~slot_vld | drain_oh);

  always_comb begin
    drain_addr = '0;
    drain_data = '0;
    for (int i = 0; i < NUM_WB_SLOTS; i++) begin
      if (drain_oh[i]) begin
        drain_addr = slot_addr[i];
        drain_data = slot_data[i];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slot_vld    <= '0;
      wb_overflow <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_WB_SLOTS; i++) begin
        if (slot_load[i]) begin
          slot_vld[i] <= 1'b1;
        end else if (drain_oh[i]) begin
          slot_vld[i] <= 1'b0;
        end
      end
      if (|(wb_stb & ~slot_load)) begin
        wb_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_WB_SLOTS; i++) begin
      if (slot_load[i]) begin
        slot_addr[i] <= stb_addr[i];
        slot_data[i] <= stb_data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (|drain_oh) begin
      mem[drain_addr] <= drain_data;
    end
  end

  for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
    logic [ADDR_W-1:0]       rd_addr;
    logic [DATA_W-1:0]       rd_data;
    logic [NUM_WB_SLOTS-1:0] match;

    assign rd_data = mem[rd_addr];

    // A draining slot is still valid this cycle, so it also holds off the read.
    always_comb begin
      for (int i = 0; i < NUM_WB_SLOTS; i++) begin
        match[i] = slot_vld[i] && (slot_addr[i] == rd_addr);
      end
    end

    mem_miss_fsm #(
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W),
      .MISS_LATENCY (MISS_LATENCY)
    ) u_miss (
      .clk               (clk),
      .resetn            (resetn),
      .bus_reply         (bus_reply[c]),
      .ask_mem_address   (ask_mem_address[c]),
      .peer_abort        (bus_reply_abort_mem_access[1-c]),
      .wb_hazard         (|match),
      .rd_data           (rd_data),
      .rd_addr           (rd_addr),
      .mem_data_delivery (mem_data_delivery[c]),
      .mem_data_valid    (mem_data_valid[c])
    );
  end

endmodule

// File: tb/tb_shared_mem_responder.sv
// Directed bench for shared_mem_responder: reset, miss latency, peer abort,
// read-after-write ordering, write-back drain order/overflow, dual-core delivery.
module tb_shared_mem_responder;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  logic                   clk;
  logic                   resetn;
  logic [1:0][1:0]        bus_reply;
  logic [1:0][ADDR_W-1:0] ask_mem_address;
  logic [1:0]             bus_reply_abort_mem_access;
  logic [1:0]             cpu_write_back;
  logic [1:0]             bus_write_back;
  logic [1:0][ADDR_W-1:0] address_out_mem_cpu;
  logic [1:0][ADDR_W-1:0] address_out_mem_bus;
  logic [1:0][DATA_W-1:0] data_out_mem_cpu;
  logic [1:0][DATA_W-1:0] data_out_mem_bus;
  logic [1:0][DATA_W-1:0] mem_data_delivery;
  logic [1:0]             mem_data_valid;
  logic                   wb_overflow;

  int checks = 0;
  int errors = 0;

  shared_mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MISS_LATENCY(2)) dut (
    .clk                        (clk),
    .resetn                     (resetn),
    .bus_reply                  (bus_reply),
    .ask_mem_address            (ask_mem_address),
    .bus_reply_abort_mem_access (bus_reply_abort_mem_access),
    .cpu_write_back             (cpu_write_back),
    .bus_write_back             (bus_write_back),
    .address_out_mem_cpu        (address_out_mem_cpu),
    .address_out_mem_bus        (address_out_mem_bus),
    .data_out_mem_cpu           (data_out_mem_cpu),
    .data_out_mem_bus           (data_out_mem_bus),
    .mem_data_delivery          (mem_data_delivery),
    .mem_data_valid             (mem_data_valid),
    .wb_overflow                (wb_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_reply                  = {2'b11, 2'b11};
    ask_mem_address            = '0;
    bus_reply_abort_mem_access = '0;
    cpu_write_back             = '0;
    bus_write_back             = '0;
    address_out_mem_cpu        = '0;
    address_out_mem_bus        = '0;
    data_out_mem_cpu           = '0;
    data_out_mem_bus           = '0;
  endtask

  // src: 0 c0.cpu, 1 c0.bus, 2 c1.cpu, 3 c1.bus (strobe left asserted for the caller to clear)
  task automatic set_wb(input int src, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    case (src)
      0: begin cpu_write_back[0] = 1'b1; address_out_mem_cpu[0] = a; data_out_mem_cpu[0] = d; end
      1: begin bus_write_back[0] = 1'b1; address_out_mem_bus[0] = a; data_out_mem_bus[0] = d; end
      2: begin cpu_write_back[1] = 1'b1; address_out_mem_cpu[1] = a; data_out_mem_cpu[1] = d; end
      default: begin bus_write_back[1] = 1'b1; address_out_mem_bus[1] = a; data_out_mem_bus[1] = d; end
    endcase
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    set_wb(0, a, d);
    tick();
    cpu_write_back = '0;
    bus_write_back = '0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle_inputs();
    tick();
    tick();
    checks++;
    if (mem_data_valid !== 2'b00) begin
      errors++; $display("FAIL reset_valid: got %b expected 00", mem_data_valid);
    end
    checks++;
    if (mem_data_delivery !== '0) begin
      errors++; $display("FAIL reset_delivery: got %h expected 0", mem_data_delivery);
    end
    checks++;
    if (wb_overflow !== 1'b0) begin
      errors++; $display("FAIL reset_overflow: got %b expected 0", wb_overflow);
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_read_miss();
    preload(9'h005, 32'hDEADBEEF);
    bus_reply[0] = 2'b10;
    ask_mem_address[0] = 9'h005;
    tick();
    bus_reply[0] = 2'b11;
    tick();
    tick();
    checks++;
    if (mem_data_valid[0] !== 1'b0) begin
      errors++; $display("FAIL miss_early_valid T+3: got %b expected 0", mem_data_valid[0]);
    end
    tick();
    checks++;
    if (mem_data_valid[0] !== 1'b1 || mem_data_delivery[0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL miss_deliver T+4: got valid %b data %h expected 1 deadbeef",
                         mem_data_valid[0], mem_data_delivery[0]);
    end
    checks++;
    if (mem_data_valid[1] !== 1'b0) begin
      errors++; $display("FAIL miss_other_core: got %b expected 0", mem_data_valid[1]);
    end
    tick();
    checks++;
    if (mem_data_valid[0] !== 1'b0 || mem_data_delivery[0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL miss_hold T+5: got valid %b data %h expected 0 deadbeef",
                         mem_data_valid[0], mem_data_delivery[0]);
    end
  endtask

  task automatic test_abort();
    int seen;
    preload(9'h010, 32'h12345678);
    // Abort in WAIT, then a fresh request at T+3 must be accepted.
    bus_reply[1] = 2'b01;
    ask_mem_address[1] = 9'h010;
    tick();
    bus_reply[1] = 2'b11;
    tick();
    bus_reply_abort_mem_access[0] = 1'b1;
    tick();
    bus_reply_abort_mem_access[0] = 1'b0;
    bus_reply[1] = 2'b10;
    tick();
    bus_reply[1] = 2'b11;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (mem_data_valid[1] === 1'b1) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL abort_wait: got %0d valid pulses expected 0", seen);
    end
    checks++;
    if (mem_data_valid[1] !== 1'b1 || mem_data_delivery[1] !== 32'h12345678) begin
      errors++; $display("FAIL abort_reissue: got valid %b data %h expected 1 12345678",
                         mem_data_valid[1], mem_data_delivery[1]);
    end
    tick();
    // Abort in the READ cycle of core0's miss.
    bus_reply[0] = 2'b10;
    ask_mem_address[0] = 9'h010;
    tick();
    bus_reply[0] = 2'b11;
    tick();
    tick();
    bus_reply_abort_mem_access[1] = 1'b1;
    tick();
    bus_reply_abort_mem_access[1] = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (mem_data_valid[0] === 1'b1) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL abort_read: got %0d valid pulses expected 0", seen);
    end
  endtask

  task automatic test_raw_same_cycle();
    preload(9'h00A, 32'hAAAA0000);
    set_wb(0, 9'h00A, 32'h00001111);
    bus_reply[1] = 2'b10;
    ask_mem_address[1] = 9'h00A;
    tick();
    cpu_write_back = '0;
    bus_reply[1] = 2'b11;
    tick();
    tick();
    tick();
    checks++;
    if (mem_data_valid[1] !== 1'b1 || mem_data_delivery[1] !== 32'h00001111) begin
      errors++; $display("FAIL raw_same_cycle: got valid %b data %h expected 1 00001111",
                         mem_data_valid[1], mem_data_delivery[1]);
    end
    tick();
  endtask

  task automatic test_raw_stall();
    preload(9'h00B, 32'hBBBB0000);
    set_wb(0, 9'h030, 32'h30);
    set_wb(1, 9'h031, 32'h31);
    set_wb(2, 9'h032, 32'h32);
    set_wb(3, 9'h00B, 32'hB0B0B0B0);
    bus_reply[0] = 2'b10;
    ask_mem_address[0] = 9'h00B;
    tick();
    cpu_write_back = '0;
    bus_write_back = '0;
    bus_reply[0] = 2'b11;
    tick();
    tick();
    tick();
    checks++;
    if (mem_data_valid[0] !== 1'b0) begin
      errors++; $display("FAIL raw_stall T+4: got %b expected 0", mem_data_valid[0]);
    end
    tick();
    checks++;
    if (mem_data_valid[0] !== 1'b0) begin
      errors++; $display("FAIL raw_stall T+5: got %b expected 0", mem_data_valid[0]);
    end
    tick();
    checks++;
    if (mem_data_valid[0] !== 1'b1 || mem_data_delivery[0] !== 32'hB0B0B0B0) begin
      errors++; $display("FAIL raw_stall T+6: got valid %b data %h expected 1 b0b0b0b0",
                         mem_data_valid[0], mem_data_delivery[0]);
    end
    tick();
  endtask

  task automatic test_free_on_drain();
    set_wb(0, 9'h040, 32'h4000_0001);
    tick();
    set_wb(0, 9'h041, 32'h4000_0002);
    tick();
    cpu_write_back = '0;
    tick();
    tick();
    checks++;
    if (wb_overflow !== 1'b0) begin
      errors++; $display("FAIL drain_free_overflow: got %b expected 0", wb_overflow);
    end
    checks++;
    if (dut.mem[9'h040] !== 32'h4000_0001 || dut.mem[9'h041] !== 32'h4000_0002) begin
      errors++; $display("FAIL drain_free_data: got %h %h expected 40000001 40000002",
                         dut.mem[9'h040], dut.mem[9'h041]);
    end
  endtask

  task automatic test_wb_burst();
    logic [DATA_W-1:0] exp;
    for (int i = 0; i < 4; i++) preload(ADDR_W'(32 + i), 32'h0);
    for (int i = 0; i < 4; i++) set_wb(i, ADDR_W'(32 + i), 32'hC0DE0000 + 32'(i));
    tick();
    cpu_write_back = '0;
    bus_write_back = '0;
    set_wb(3, 9'h023, 32'h00000BAD);
    checks++;
    if (dut.mem[9'h020] !== 32'h0) begin
      errors++; $display("FAIL burst_T+1 mem[20]: got %h expected 0", dut.mem[9'h020]);
    end
    tick();
    bus_write_back = '0;
    checks++;
    if (wb_overflow !== 1'b1) begin
      errors++; $display("FAIL burst_overflow: got %b expected 1", wb_overflow);
    end
    // After k+2 ticks slot k has landed and slot k+1 has not.
    for (int k = 0; k < 4; k++) begin
      exp = 32'hC0DE0000 + 32'(k);
      checks++;
      if (dut.mem[32 + k] !== exp) begin
        errors++; $display("FAIL burst_slot%0d landed: got %h expected %h", k, dut.mem[32 + k], exp);
      end
      if (k < 3) begin
        checks++;
        if (dut.mem[33 + k] !== 32'h0) begin
          errors++; $display("FAIL burst_slot%0d early: got %h expected 0", k + 1, dut.mem[33 + k]);
        end
      end
      tick();
    end
    checks++;
    if (wb_overflow !== 1'b1) begin
      errors++; $display("FAIL burst_overflow_sticky: got %b expected 1", wb_overflow);
    end
  endtask

  task automatic test_both_cores();
    preload(9'h001, 32'h01010101);
    preload(9'h002, 32'h02020202);
    bus_reply = {2'b10, 2'b10};
    ask_mem_address[0] = 9'h001;
    ask_mem_address[1] = 9'h002;
    tick();
    bus_reply = {2'b11, 2'b11};
    tick();
    tick();
    tick();
    checks++;
    if (mem_data_valid !== 2'b11) begin
      errors++; $display("FAIL both_valid: got %b expected 11", mem_data_valid);
    end
    checks++;
    if (mem_data_delivery[0] !== 32'h01010101 || mem_data_delivery[1] !== 32'h02020202) begin
      errors++; $display("FAIL both_data: got %h %h expected 01010101 02020202",
                         mem_data_delivery[0], mem_data_delivery[1]);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    int seen;
    bus_reply[0] = 2'b10;
    ask_mem_address[0] = 9'h005;
    tick();
    bus_reply[0] = 2'b11;
    tick();
    resetn = 1'b0;
    #1;
    checks++;
    if (mem_data_valid !== 2'b00 || mem_data_delivery !== '0 || wb_overflow !== 1'b0) begin
      errors++; $display("FAIL reset_mid_wait: got valid %b data %h ovf %b expected 00 0 0",
                         mem_data_valid, mem_data_delivery, wb_overflow);
    end
    tick();
    resetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (mem_data_valid !== 2'b00) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL reset_no_pulse: got %0d valid cycles expected 0", seen);
    end
    // Memory contents survive reset.
    bus_reply[0] = 2'b10;
    ask_mem_address[0] = 9'h005;
    tick();
    bus_reply[0] = 2'b11;
    tick();
    tick();
    tick();
    checks++;
    if (mem_data_valid[0] !== 1'b1 || mem_data_delivery[0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL reset_mem_retained: got valid %b data %h expected 1 deadbeef",
                         mem_data_valid[0], mem_data_delivery[0]);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_abort();
    test_raw_same_cycle();
    test_raw_stall();
    test_free_on_drain();
    test_wb_burst();
    test_both_cores();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
